// File: rtl/fetch_pkg.sv
// Package: fetch_pkg
// Shared state encoding and default sizes for the instruction fetch stage.
package fetch_pkg;

   localparam int          ADDR_W_DEF   = 16;
   localparam int          DATA_W_DEF   = 16;
   localparam logic [15:0] RESET_PC_DEF = 16'h0000;
   localparam int          PC_STEP      = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Module: fetch_fifo
// Prefetch FIFO holding {pc, instruction} pairs; flush empties it and overrides push/pop.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty
);
   localparam int            PW      = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    rd_ptr_r;
   logic [PW-1:0]    wr_ptr_r;
   logic [PW:0]      count_r;
   logic             full_s;
   logic             do_push_s;
   logic             do_pop_s;

   // DEPTH is a power of two, so the count MSB alone marks full
   assign full_s    = count_r[PW];
   assign empty     = (count_r == {(PW+1){1'b0}});
   assign do_push_s = push && !full_s;
   assign do_pop_s  = pop && !empty;
   assign rdata     = mem_r[rd_ptr_r];
   assign count     = count_r;

   // Entry storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else if (do_push_s && !flush) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         count_r  <= {(PW+1){1'b0}};
      end else if (flush) begin
         rd_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         count_r  <= {(PW+1){1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Module: fetch_unit
// Instruction fetch stage: one-outstanding memory reads, prefetch FIFO, redirect flush and sticky halt.
// Build macro FETCH_PERF_EN adds saturating pop and stall counters.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                DATA_W   = DATA_W_DEF,
   parameter int                DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              instr_ready,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              hlt
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]       perf_fetch_cnt,
   output logic [31:0]       perf_stall_cnt
`endif
);
   localparam int                CW      = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
   localparam logic [ADDR_W-1:0] PC_INC  = ADDR_W'(PC_STEP);
   localparam logic [ADDR_W-1:0] PC_MASK = ~ADDR_W'(1);

   fetch_state_e             state_r;
   fetch_state_e             state_s;
   logic                     issue_s;
   logic                     push_s;
   logic                     pop_s;
   logic                     fifo_empty_s;
   logic [CW-1:0]            fifo_count_s;
   logic [ADDR_W+DATA_W-1:0] fifo_head_s;
   logic [ADDR_W-1:0]        fetch_pc_r;
   logic                     halted_r;

   // mem_addr holds the outstanding request's PC until the next issue, so it tags the pushed word
   assign push_s      = (state_r == WAIT) && mem_rvalid && !redirect;
   assign pop_s       = instr_valid && instr_ready && !redirect;
   assign instr_valid = !fifo_empty_s;
   assign {instr_pc, instr} = fifo_head_s;

   // Next-state and issue decision
   always_comb begin
      state_s = state_r;
      issue_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (!halted_r && !hlt && !redirect && (fifo_count_s < DEPTH_C)) begin
               issue_s = 1'b1;
               state_s = WAIT;
            end else begin
               state_s = IDLE;
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               state_s = IDLE;
            end else if (redirect) begin
               state_s = DROP;
            end else begin
               state_s = WAIT;
            end
         end
         DROP: begin
            if (mem_rvalid) begin
               state_s = IDLE;
            end else begin
               state_s = DROP;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Fetch PC, sticky halt and registered memory request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_r <= RESET_PC;
         halted_r   <= 1'b0;
         mem_req    <= 1'b0;
         mem_addr   <= {ADDR_W{1'b0}};
      end else begin
         mem_req <= issue_s;
         if (issue_s) begin
            mem_addr <= fetch_pc_r;
         end
         if (redirect) begin
            fetch_pc_r <= redirect_pc & PC_MASK;
         end else if (issue_s) begin
            fetch_pc_r <= fetch_pc_r + PC_INC;
         end
         if (hlt) begin
            halted_r <= 1'b1;
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ADDR_W + DATA_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .pop   (pop_s),
      .flush (redirect),
      .wdata ({mem_addr, mem_rdata}),
      .rdata (fifo_head_s),
      .count (fifo_count_s),
      .empty (fifo_empty_s)
   );

`ifdef FETCH_PERF_EN
   // Saturating delivered-instruction and starvation counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_cnt <= 32'd0;
         perf_stall_cnt <= 32'd0;
      end else begin
         if (pop_s && (perf_fetch_cnt != 32'hFFFF_FFFF)) begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         end
         if (!instr_valid && !halted_r && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
